// File: rtl/clock_pkg.sv
// Shared mode encoding for the clock-enable generator.
package clock_pkg;

  localparam logic [2:0] MODE_MANUAL = 3'd0;
  localparam logic [2:0] MODE_SLOW   = 3'd1;
  localparam logic [2:0] MODE_FAST   = 3'd2;
  localparam logic [2:0] MODE_FULL   = 3'd3;
  localparam logic [2:0] MODE_BURST  = 3'd4;
  localparam logic [2:0] MODE_LAST   = MODE_BURST;

  function automatic logic [2:0] nextMode(input logic [2:0] m);
    return (m == MODE_LAST) ? MODE_MANUAL : m + 3'd1;
  endfunction

endpackage

// File: rtl/clock_enable_gen_if.sv
// Button/limit inputs and tick/status outputs of the clock-enable generator.
interface clock_enable_gen_if #(parameter int LIMIT_WIDTH = 8);

  logic                   iModeStep;
  logic                   iManualStep;
  logic [LIMIT_WIDTH-1:0] iLimit;
  logic                   oTick;
  logic [2:0]             oMode;
  logic                   oBusy;

  modport master (output iModeStep, iManualStep, iLimit, input oTick, oMode, oBusy);
  modport slave  (input iModeStep, iManualStep, iLimit, output oTick, oMode, oBusy);

endinterface

// File: rtl/button_debounce.sv
// Raw button -> 2-FF sync -> stable-count debounce -> one-cycle rise event.
module button_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic iClock,
  input  logic iReset_n,
  input  logic iButton,
  output logic oLevel,
  output logic oRise
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    syncPipe;
  logic [DW-1:0] stableCnt;
  logic          levelD;

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      syncPipe  <= '0;
      stableCnt <= '0;
      oLevel    <= 1'b0;
      levelD    <= 1'b0;
    end else begin
      syncPipe <= {syncPipe[0], iButton};
      levelD   <= oLevel;
      // any agreement with the accepted level restarts the stability count
      if (syncPipe[1] == oLevel) begin
        stableCnt <= '0;
      end else if (stableCnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        oLevel    <= syncPipe[1];
        stableCnt <= '0;
      end else begin
        stableCnt <= stableCnt + 1'b1;
      end
    end
  end

  assign oRise = oLevel & ~levelD;

endmodule

// File: rtl/clock_enable_gen.sv
// Mode-selectable single-cycle clock-enable source: manual, slow, fast, full, burst.
module clock_enable_gen
  import clock_pkg::*;
#(
  parameter int LIMIT_WIDTH     = 8,
  parameter int SLOW_SHIFT      = 16,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int BURST_LEN       = 8
) (
  input  logic               iClock,
  input  logic               iReset_n,
  clock_enable_gen_if.slave  bus
);

  localparam int CW = LIMIT_WIDTH + SLOW_SHIFT;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  // index 1 = mode button, index 0 = step button
  logic [1:0] btnRaw, btnRise, unusedBtnLevel;
  assign btnRaw = {bus.iModeStep, bus.iManualStep};

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uBtn [1:0] (
    .iClock   (iClock),
    .iReset_n (iReset_n),
    .iButton  (btnRaw),
    .oLevel   (unusedBtnLevel),
    .oRise    (btnRise)
  );

  logic                   modeEv, stepEv;
  logic [2:0]             mode;
  logic [CW-1:0]          cnt, cntNext;
  logic [LIMIT_WIDTH-1:0] shadow, shadowNext;
  logic [BW-1:0]          burstCnt;
  logic                   busy, tick, wrap, tickNext;

  assign modeEv = btnRise[1];
  assign stepEv = btnRise[0];

  function automatic logic [CW-1:0] effLimit(input logic [2:0] m, input logic [LIMIT_WIDTH-1:0] s);
    return (m == MODE_SLOW) ? (CW'(s) << SLOW_SHIFT) : CW'(s);
  endfunction

  // Tick is registered but lands in the same cycle the counter sits at E,
  // so it is decided from the counter/shadow values of the following cycle.
  always_comb begin
    wrap       = (cnt == effLimit(mode, shadow));
    cntNext    = wrap ? '0 : cnt + 1'b1;
    shadowNext = wrap ? bus.iLimit : shadow;
    tickNext   = (cntNext == effLimit(mode, shadowNext));
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      mode     <= MODE_MANUAL;
      cnt      <= '0;
      shadow   <= '0;
      burstCnt <= '0;
      busy     <= 1'b0;
      tick     <= 1'b0;
    end else if (modeEv) begin
      mode     <= nextMode(mode);
      cnt      <= '0;
      shadow   <= bus.iLimit;
      burstCnt <= '0;
      busy     <= 1'b0;
      tick     <= 1'b0;
    end else begin
      case (mode)
        MODE_MANUAL: tick <= stepEv;
        MODE_SLOW, MODE_FAST: begin
          cnt    <= cntNext;
          shadow <= shadowNext;
          tick   <= tickNext;
        end
        MODE_FULL: tick <= 1'b1;
        MODE_BURST: begin
          if (!busy) begin
            tick <= 1'b0;
            if (stepEv) begin
              busy     <= 1'b1;
              cnt      <= '0;
              shadow   <= bus.iLimit;
              burstCnt <= '0;
              tick     <= (bus.iLimit == '0);
            end
          end else begin
            cnt    <= cntNext;
            shadow <= shadowNext;
            tick   <= tickNext;
            if (wrap) begin
              burstCnt <= burstCnt + 1'b1;
              if (burstCnt == BW'(BURST_LEN - 1)) begin
                busy <= 1'b0;
                tick <= 1'b0;
              end
            end
          end
        end
        default: tick <= 1'b0;
      endcase
    end
  end

  assign bus.oTick = tick;
  assign bus.oMode = mode;
  assign bus.oBusy = busy;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Scoreboard bench: stimulus queues expected tick cycles, a negedge monitor pops and compares.
module tb_clock_enable_gen;

  localparam int LW = 8, SS = 4, DB = 4, BL = 3, LOGN = 4096;

  logic clk = 1'b0;
  logic rstN = 1'b0;

  clock_enable_gen_if #(.LIMIT_WIDTH(LW)) bus();

  clock_enable_gen #(
    .LIMIT_WIDTH(LW), .SLOW_SHIFT(SS), .DEBOUNCE_CYCLES(DB), .BURST_LEN(BL)
  ) dut (
    .iClock   (clk),
    .iReset_n (rstN),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int nTests = 0, nFail = 0;
  int winLo = 0, winHi = 0;
  int expQ[$];
  logic       busyLog[LOGN];
  logic [2:0] modeLog[LOGN];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ticks inside the open window must match the queued cycle numbers in order
  initial forever begin
    @(negedge clk);
    if (cyc < LOGN) begin
      busyLog[cyc] = bus.oBusy;
      modeLog[cyc] = bus.oMode;
    end
    if (cyc >= winLo && cyc < winHi && bus.oTick) begin
      if (expQ.size() == 0) check("tick_extra", cyc, -1);
      else                  check("tick_cycle", cyc, expQ.pop_front());
    end
  end

  task automatic step1();
    @(posedge clk); #1;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) step1();
  endtask

  task automatic drive(input int s0, s1, s2, s3, m0, m1, total);
    for (int k = 0; k < total; k++) begin
      bus.iManualStep = ((k >= s0) && (k < s1)) || ((k >= s2) && (k < s3));
      bus.iModeStep   = (k >= m0) && (k < m1);
      step1();
    end
    bus.iManualStep = 1'b0;
    bus.iModeStep   = 1'b0;
  endtask

  task automatic modePress();
    drive(0, 0, 0, 0, 0, 10, 20);
  endtask

  task automatic openWin(input int lo, input int hi);
    expQ.delete();
    winLo = lo;
    winHi = hi;
  endtask

  task automatic closeWin(input string name);
    waitUntil(winHi);
    check(name, expQ.size(), 0);
    expQ.delete();
    winHi = 0;
  endtask

  int p;

  initial begin
    bus.iModeStep = 1'b0; bus.iManualStep = 1'b0; bus.iLimit = '0;
    repeat (3) step1();
    check("rst_tick", bus.oTick, 0);
    check("rst_mode", bus.oMode, 0);
    check("rst_busy", bus.oBusy, 0);
    rstN = 1'b1;
    step1();

    // MANUAL: 10-cycle press gives one tick 7 cycles later; 2-cycle chatter gives none
    p = cyc; openWin(p + 1, p + 60); expQ.push_back(p + 7);
    drive(0, 10, 0, 0, 0, 0, 22);
    for (int k = 0; k < 20; k++) begin
      bus.iManualStep = ((k / 2) % 2 == 0);
      step1();
    end
    bus.iManualStep = 1'b0;
    closeWin("manual_q");

    // SLOW, L=2: E=32, period 33
    bus.iLimit = 2; p = cyc; openWin(p + 7, p + 80);
    expQ.push_back(p + 39); expQ.push_back(p + 72);
    modePress(); closeWin("slow_q");
    check("mode_latency", modeLog[p + 6], 0);
    check("mode_slow", modeLog[p + 7], 1);

    // FAST, L=3: period 4
    bus.iLimit = 3; p = cyc; openWin(p + 7, p + 40);
    for (int t = p + 10; t < p + 40; t += 4) expQ.push_back(t);
    modePress(); closeWin("fast_q");
    check("mode_fast", modeLog[p + 7], 2);

    // FAST, L=0: tick every cycle
    bus.iLimit = 0; repeat (6) step1();
    p = cyc; openWin(p + 1, p + 9);
    for (int t = p + 1; t < p + 9; t++) expQ.push_back(t);
    closeWin("fast0_q");

    // limit 9 -> 2 while the counter is at 5: period 10 finishes, then period 3
    p = cyc; bus.iLimit = 9; openWin(p + 1, p + 25);
    expQ.push_back(p + 10);
    for (int t = p + 13; t < p + 25; t += 3) expQ.push_back(t);
    waitUntil(p + 6); bus.iLimit = 2;
    closeWin("limchg_q");

    // FULL
    p = cyc; modePress();
    check("mode_full", modeLog[p + 7], 3);
    check("full_tick", bus.oTick, 1);

    // BURST entry
    bus.iLimit = 1; p = cyc; modePress();
    check("mode_burst", modeLog[p + 7], 4);
    check("burst_idle", bus.oBusy, 0);

    // burst L=1: ticks t+2, t+4, t+6 after event t=p+6; busy p+7..p+12
    p = cyc; openWin(p + 1, p + 25);
    expQ.push_back(p + 8); expQ.push_back(p + 10); expQ.push_back(p + 12);
    drive(0, 6, 0, 0, 0, 0, 25); closeWin("burst_q");
    check("busy_pre", busyLog[p + 6], 0);
    check("busy_rise", busyLog[p + 7], 1);
    check("busy_last", busyLog[p + 12], 1);
    check("busy_fall", busyLog[p + 13], 0);

    // burst L=4 with a second step event at p+16 that must be ignored
    bus.iLimit = 4; p = cyc; openWin(p + 1, p + 40);
    expQ.push_back(p + 11); expQ.push_back(p + 16); expQ.push_back(p + 21);
    drive(0, 5, 10, 15, 0, 0, 40); closeWin("burst_ign_q");
    check("busy_mid", busyLog[p + 16], 1);
    check("busy_last2", busyLog[p + 21], 1);
    check("busy_fall2", busyLog[p + 22], 0);

    // mode event at p+9 aborts the burst after its first tick
    bus.iLimit = 1; p = cyc; openWin(p + 1, p + 30);
    expQ.push_back(p + 8);
    drive(0, 6, 0, 0, 3, 9, 30); closeWin("abort_q");
    check("abort_mode_pre", modeLog[p + 9], 4);
    check("abort_busy_pre", busyLog[p + 9], 1);
    check("abort_mode", modeLog[p + 10], 0);
    check("abort_busy", busyLog[p + 10], 0);

    // five mode presses wrap back to MANUAL
    for (int i = 1; i <= 5; i++) begin
      p = cyc; modePress();
      check("mode_wrap", modeLog[p + 7], i % 5);
    end

    // simultaneous mode and step events from BURST: mode wins, no burst
    repeat (4) modePress();
    p = cyc; openWin(p + 1, p + 25);
    drive(0, 6, 0, 0, 0, 6, 25); closeWin("simul_q");
    check("simul_mode", modeLog[p + 7], 0);
    check("simul_busy", busyLog[p + 7], 0);

    // asynchronous reset mid-burst
    repeat (4) modePress();
    bus.iLimit = 1; p = cyc; openWin(p + 1, p + 10);
    expQ.push_back(p + 8);
    drive(0, 6, 0, 0, 0, 0, 6);
    waitUntil(p + 10); closeWin("prerst_q");
    check("prerst_tick", bus.oTick, 1);
    check("prerst_busy", bus.oBusy, 1);
    #2 rstN = 1'b0;
    #1;
    check("arst_tick", bus.oTick, 0);
    check("arst_busy", bus.oBusy, 0);
    check("arst_mode", bus.oMode, 0);
    repeat (2) step1();
    check("arst_hold_mode", bus.oMode, 0);
    rstN = 1'b1;
    step1();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
